rr_mux2_stream: RTL and testbench

Two-input registered stream multiplexer. It places the 2:1 select datapath behind valid/ready handshakes and drives the select from a round-robin arbiter instead of a free input. It sits directly downstream of two producers and feeds one consumer through a single output register stage. Per-input saturating acceptance counters are included for debug and verification.

---
 rtl/rr_mux2_stream.sv | 67 ++++++
 tb/tb_rr_mux2_stream.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/rr_mux2_stream.sv
// Two-input stream mux with a round-robin select, one output register stage
// and per-input saturating acceptance counters.
module rr_mux2_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic prio;
  logic load_en;
  logic grant_a;
  logic grant_b;

  // Ready terms look only at the opposite valid, so no valid->own-ready loop.
  assign load_en = !out_valid || out_ready;
  assign a_ready = load_en && (!prio || !b_valid);
  assign b_ready = load_en && (prio || !a_valid);
  assign grant_a = a_valid && a_ready;
  assign grant_b = b_valid && b_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 1'b0;
      prio      <= 1'b0;
    end else if (grant_a) begin
      out_valid <= 1'b1;
      out_data  <= a_data;
      out_sel   <= 1'b0;
      prio      <= 1'b1;
    end else if (grant_b) begin
      out_valid <= 1'b1;
      out_data  <= b_data;
      out_sel   <= 1'b1;
      prio      <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Debug counters stick at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (grant_a && (cnt_a != '1)) cnt_a <= cnt_a + CNT_W'(1);
      if (grant_b && (cnt_b != '1)) cnt_b <= cnt_b + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rr_mux2_stream.sv
// Directed self-checking bench for rr_mux2_stream, plus a CNT_W=2 instance
// for counter saturation.
module tb_rr_mux2_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_valid, b_valid, out_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, out_valid, out_sel;
  logic [7:0] out_data, cnt_a, cnt_b;

  logic       s_b_valid;
  logic [7:0] s_b_data;
  logic       s_a_ready, s_b_ready, s_out_valid, s_out_sel;
  logic [7:0] s_out_data;
  logic [1:0] s_cnt_a, s_cnt_b;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  rr_mux2_stream #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  rr_mux2_stream #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .a_valid(1'b0), .a_data(8'h00), .a_ready(s_a_ready),
    .b_valid(s_b_valid), .b_data(s_b_data), .b_ready(s_b_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_sel(s_out_sel),
    .out_ready(1'b1), .cnt_a(s_cnt_a), .cnt_b(s_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    a_data = 8'h00; b_data = 8'h00; s_b_valid = 1'b0; s_b_data = 8'h00;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_a_ready",   32'(a_ready),   32'd1);
    chk("rst_b_ready",   32'(b_ready),   32'd1);
    chk("rst_cnt_a",     32'(cnt_a),     32'd0);
    tick(); tick();
    reset = 1'b0;

    // A only, consumer ready
    a_valid = 1'b1; a_data = 8'h11;
    tick();
    chk("a1_data", 32'(out_data), 32'h11);
    chk("a1_sel",  32'(out_sel),  32'd0);
    chk("a1_vld",  32'(out_valid), 32'd1);
    a_data = 8'h22;
    tick();
    chk("a2_data", 32'(out_data), 32'h22);
    chk("a2_sel",  32'(out_sel),  32'd0);
    a_data = 8'h33;
    tick();
    chk("a3_data", 32'(out_data), 32'h33);
    chk("a3_cnt",  32'(cnt_a),    32'd3);
    a_valid = 1'b0;

    // Asynchronous reset with a word in flight
    reset = 1'b1;
    #1;
    chk("mrst_vld",   32'(out_valid), 32'd0);
    chk("mrst_data",  32'(out_data),  32'h00);
    chk("mrst_cnt_a", 32'(cnt_a),     32'd0);
    chk("mrst_cnt_b", 32'(cnt_b),     32'd0);
    #2;
    reset = 1'b0;

    // Contention: strict alternation from prio = A
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hA0; b_data = 8'hB0;
    #1;
    chk("cont_a_ready", 32'(a_ready), 32'd1);
    chk("cont_b_ready", 32'(b_ready), 32'd0);
    tick();
    chk("c1", {23'd0, out_sel, out_data}, {23'd0, 1'b0, 8'hA0});
    a_data = 8'hA1;
    tick();
    chk("c2", {23'd0, out_sel, out_data}, {23'd0, 1'b1, 8'hB0});
    b_data = 8'hB1;
    tick();
    chk("c3", {23'd0, out_sel, out_data}, {23'd0, 1'b0, 8'hA1});
    a_data = 8'hA2;
    tick();
    chk("c4", {23'd0, out_sel, out_data}, {23'd0, 1'b1, 8'hB1});
    chk("c_cnt_a", 32'(cnt_a), 32'd2);
    chk("c_cnt_b", 32'(cnt_b), 32'd2);

    // Backpressure
    b_valid = 1'b0; a_data = 8'h5C;
    tick();
    chk("bp_load", 32'(out_data), 32'h5C);
    out_ready = 1'b0; b_valid = 1'b1; a_data = 8'hA9; b_data = 8'hB9;
    #1;
    chk("bp_a_ready", 32'(a_ready), 32'd0);
    chk("bp_b_ready", 32'(b_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_data", 32'(out_data), 32'h5C);
      chk("bp_hold_vld",  32'(out_valid), 32'd1);
      chk("bp_hold_cnt",  {16'd0, cnt_a, cnt_b}, {16'd0, 8'd3, 8'd2});
    end
    out_ready = 1'b1;
    #1;
    chk("rel_b_ready", 32'(b_ready), 32'd1);
    chk("rel_a_ready", 32'(a_ready), 32'd0);
    tick();
    chk("rel_word", {23'd0, out_sel, out_data}, {23'd0, 1'b1, 8'hB9});
    chk("rel_cnt_b", 32'(cnt_b), 32'd3);

    // Drain only
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    chk("drain_vld",  32'(out_valid), 32'd0);
    chk("drain_data", 32'(out_data),  32'hB9);
    chk("drain_sel",  32'(out_sel),   32'd1);
    chk("drain_cnt",  {16'd0, cnt_a, cnt_b}, {16'd0, 8'd3, 8'd3});

    // Saturation on the CNT_W=2 instance
    s_b_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      s_b_data = 8'(8'h60 + i);
      tick();
      chk("sat_word", {23'd0, s_out_valid, s_out_data}, {23'd0, 1'b1, 8'(8'h60 + i)});
      chk("sat_cnt", 32'(s_cnt_b), (i < 3) ? 32'(i) : 32'd3);
    end
    s_b_valid = 1'b0;
    chk("sat_cnt_a", 32'(s_cnt_a), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
